// File: rtl/wr_sdram_if.sv
// wr_sdram_if: FIFO-side and SDRAM-controller-side signals of the field writer.
interface wr_sdram_if;
  logic [9:0] rdusedw_fifo;
  logic [15:0] dout_fifo;
  logic rdempty_fifo;
  logic rd_en_fifo;
  logic fifo_aclr;
  logic wr_req;
  logic [8:0] wr_data_length;
  logic [21:0] wr_addr_base;
  logic [15:0] wr_data;
  logic wr_data_valid;
  logic field_done;
  modport master (
    input rdusedw_fifo, dout_fifo, rdempty_fifo, wr_data_valid,
    output rd_en_fifo, fifo_aclr, wr_req, wr_data_length, wr_addr_base, wr_data, field_done
  );
  modport slave (
    output rdusedw_fifo, dout_fifo, rdempty_fifo, wr_data_valid,
    input rd_en_fifo, fifo_aclr, wr_req, wr_data_length, wr_addr_base, wr_data, field_done
  );
endinterface

// File: rtl/wr_sdram.sv
// wr_sdram: streams video lines from a show-ahead FIFO into SDRAM as write bursts,
// one SDRAM row per burst, restarting at row 0 on every field sync.
module wr_sdram #(
  parameter int BURST_LEN = 256,
  parameter int LAST_LEN = 32,
  parameter int BURSTS_PER_LINE = 4,
  parameter int LINES_MAX = 288
) (
  input logic clk_sdram,
  input logic reset_n,
  input logic vs,
  wr_sdram_if.master bus
);
  localparam logic [4:0] IDLE = 5'b00001, WR_REQ = 5'b00010, WR_BURST = 5'b00100,
                         FSM_AROUND = 5'b01000, HOLD = 5'b10000;
  localparam logic [8:0] BL = 9'(BURST_LEN), LL = 9'(LAST_LEN), LM = 9'(LINES_MAX);
  localparam logic [7:0] BLAST = 8'(BURSTS_PER_LINE - 1);
  logic [4:0] state;
  logic vs_d1, vs_d2, vs_pos;
  logic [13:0] row_addr;
  logic [7:0] burst_cnt;
  logic [8:0] line_cnt, line_nx, word_cnt, len;
  always_comb begin
    len = (burst_cnt == BLAST) ? LL : BL;
    line_nx = line_cnt + {8'b0, burst_cnt == BLAST};
    bus.rd_en_fifo = (state == WR_BURST) ? bus.wr_data_valid & ~vs_pos
                                         : (state == HOLD) & ~bus.rdempty_fifo;
    bus.wr_data = bus.dout_fifo;
  end
  always_ff @(posedge clk_sdram or negedge reset_n)
    if (!reset_n) begin
      vs_d1 <= 1'b0;
      vs_d2 <= 1'b0;
      vs_pos <= 1'b0;
      bus.fifo_aclr <= 1'b0;
      bus.field_done <= 1'b0;
      bus.wr_req <= 1'b0;
      bus.wr_data_length <= BL;
      bus.wr_addr_base <= '0;
      state <= IDLE;
      row_addr <= '0;
      burst_cnt <= '0;
      line_cnt <= '0;
      word_cnt <= '0;
    end else begin
      vs_d1 <= vs;
      vs_d2 <= vs_d1;
      vs_pos <= vs_d1 & ~vs_d2;
      bus.fifo_aclr <= vs_pos;
      bus.field_done <= 1'b0;
      if (vs_pos) begin
        // field sync aborts whatever is in flight, even mid-burst
        state <= IDLE;
        bus.wr_req <= 1'b0;
        bus.wr_data_length <= BL;
        bus.wr_addr_base <= '0;
        row_addr <= '0;
        burst_cnt <= '0;
        line_cnt <= '0;
        word_cnt <= '0;
      end else
        case (state)
          IDLE:
            if (bus.rdusedw_fifo >= {1'b0, len}) begin
              bus.wr_data_length <= len;
              state <= WR_REQ;
            end
          WR_REQ: begin
            bus.wr_req <= 1'b1;
            bus.wr_addr_base <= {row_addr, 8'b0};
            word_cnt <= '0;
            state <= WR_BURST;
          end
          WR_BURST:
            if (bus.wr_data_valid) begin
              bus.wr_req <= 1'b0;
              word_cnt <= word_cnt + 9'd1;
              if (word_cnt == bus.wr_data_length - 9'd1) state <= FSM_AROUND;
            end
          FSM_AROUND: begin
            bus.wr_req <= 1'b0;
            row_addr <= row_addr + 14'd1;
            burst_cnt <= (burst_cnt == BLAST) ? '0 : burst_cnt + 8'd1;
            line_cnt <= line_nx;
            state <= (line_nx == LM) ? HOLD : IDLE;
            bus.field_done <= line_nx == LM;
          end
          HOLD: bus.wr_req <= 1'b0;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_wr_sdram.sv
// tb_wr_sdram: directed + randomized checks of wr_sdram against a burst/row/line model.
module tb_wr_sdram;
  localparam int BL = 256, LL = 32, BPL = 4;
  logic clk = 1'b0, reset_n = 1'b0, vs_a = 1'b0, vs_b = 1'b0;
  int total = 0, bad = 0, rd_cnt = 0, exp_row = 0, exp_bc = 0, fd = 0;
  always #5 clk = ~clk;
  wr_sdram_if ia ();
  wr_sdram_if ib ();
  wr_sdram dut_a (.clk_sdram(clk), .reset_n(reset_n), .vs(vs_a), .bus(ia));
  wr_sdram #(.BURST_LEN(8), .LAST_LEN(4), .BURSTS_PER_LINE(2), .LINES_MAX(288)) dut_b (
    .clk_sdram(clk), .reset_n(reset_n), .vs(vs_b), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one burst on dut_a: model gives length from burst-in-line and address from row count
  task automatic run_burst(input int gap, input bit dip, input int abort);
    int len, n, cyc, k;
    logic v;
    logic [15:0] d;
    len = (exp_bc == BPL - 1) ? LL : BL;
    if (dip) begin
      ia.rdusedw_fifo = 10'($urandom_range(0, len - 1));
      repeat (3) begin @(negedge clk); chk("dip_no_req", ia.wr_req, 0); end
      ia.rdusedw_fifo = 10'($urandom_range(len, 1023));
    end
    k = 0;
    while (ia.wr_req !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    chk("req_seen", ia.wr_req, 1);
    chk("req_len", ia.wr_data_length, len);
    chk("req_addr", ia.wr_addr_base, (exp_row % 16384) << 8);
    n = 0;
    cyc = 0;
    while (n < len) begin
      if (n == abort) return;
      chk("burst_req", ia.wr_req, n == 0);
      v = gap == 0 || cyc % (gap + 1) == gap;
      d = 16'($urandom);
      ia.wr_data_valid = v;
      ia.dout_fifo = d;
      #1;
      chk("rd_en", ia.rd_en_fifo, v);
      chk("wr_data", ia.wr_data, d);
      rd_cnt += int'(ia.rd_en_fifo);
      @(negedge clk);
      n += int'(v);
      cyc++;
    end
    ia.wr_data_valid = 1'b1;
    #1;
    chk("post_burst_rd", ia.rd_en_fifo, 0);
    ia.wr_data_valid = 1'b0;
    exp_row++;
    exp_bc = (exp_bc + 1) % BPL;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k, bl;
    logic e;
    ia.rdusedw_fifo = 10'd255; ia.dout_fifo = '0; ia.rdempty_fifo = 1'b0; ia.wr_data_valid = 1'b1;
    ib.rdusedw_fifo = 10'd0; ib.dout_fifo = '0; ib.rdempty_fifo = 1'b0; ib.wr_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", ia.wr_req, 0);
    chk("rst_done", ia.field_done, 0);
    chk("rst_aclr", ia.fifo_aclr, 0);
    chk("rst_len", ia.wr_data_length, 256);
    chk("rst_addr", ia.wr_addr_base, 0);
    chk("rst_rd", ia.rd_en_fifo, 0);
    chk("rst_len_b", ib.wr_data_length, 8);
    ia.wr_data_valid = 1'b0;
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk); chk("idle_255", ia.wr_req, 0); end
    ia.rdusedw_fifo = 10'd256;
    @(negedge clk);
    chk("req_lat1", ia.wr_req, 0);
    @(negedge clk);
    chk("req_lat2", ia.wr_req, 1);
    chk("req_lat2_addr", ia.wr_addr_base, 0);
    chk("req_lat2_len", ia.wr_data_length, 256);
    // first line with the FIFO kept above threshold; burst 1 uses a 1-high/2-low strobe
    rd_cnt = 0;
    run_burst(0, 1'b0, -1);
    run_burst(2, 1'b0, -1);
    run_burst(0, 1'b0, -1);
    run_burst(int'($urandom_range(0, 2)), 1'b0, -1);
    chk("line_rd_cnt", rd_cnt, 800);
    // field sync lands at word 100 of the next burst
    run_burst(0, 1'b0, 98);
    vs_a = 1'b1;
    ia.rdusedw_fifo = 10'd0;
    #1 chk("vs_e0_rd", ia.rd_en_fifo, 1);
    @(negedge clk);
    #1 chk("vs_e1_rd", ia.rd_en_fifo, 1);
    @(negedge clk);
    #1 chk("vs_pos_rd", ia.rd_en_fifo, 0);
    chk("vs_pos_aclr", ia.fifo_aclr, 0);
    @(negedge clk);
    #1 chk("vs_idle_req", ia.wr_req, 0);
    chk("vs_idle_addr", ia.wr_addr_base, 0);
    chk("vs_idle_len", ia.wr_data_length, 256);
    chk("vs_idle_rd", ia.rd_en_fifo, 0);
    chk("vs_aclr", ia.fifo_aclr, 1);
    @(negedge clk);
    chk("vs_aclr_end", ia.fifo_aclr, 0);
    ia.wr_data_valid = 1'b0;
    vs_a = 1'b0;
    exp_row = 0;
    exp_bc = 0;
    run_burst(int'($urandom_range(0, 2)), 1'b1, -1);
    run_burst(int'($urandom_range(0, 2)), 1'b1, -1);
    run_burst(0, 1'b1, 50);
    #2 reset_n = 1'b0;
    #1 chk("arst_rd", ia.rd_en_fifo, 0);
    chk("arst_req", ia.wr_req, 0);
    chk("arst_len", ia.wr_data_length, 256);
    chk("arst_addr", ia.wr_addr_base, 0);
    chk("arst_done", ia.field_done, 0);
    chk("arst_aclr", ia.fifo_aclr, 0);
    ia.wr_data_valid = 1'b0;
    ia.rdusedw_fifo = 10'd0;
    @(negedge clk);
    reset_n = 1'b1;
    // whole field on the small instance: 288 lines of 8+4 words
    ib.rdusedw_fifo = 10'd1023;
    fd = 0;
    for (int b = 0; b < 576; b++) begin
      bl = (b % 2 == 1) ? 4 : 8;
      k = 0;
      while (ib.wr_req !== 1'b1 && k < 20) begin @(negedge clk); fd += int'(ib.field_done); k++; end
      chk("b_req_seen", ib.wr_req, 1);
      chk("b_len", ib.wr_data_length, bl);
      chk("b_addr", ib.wr_addr_base, b << 8);
      ib.wr_data_valid = 1'b1;
      repeat (bl) begin @(negedge clk); fd += int'(ib.field_done); end
      ib.wr_data_valid = 1'b0;
    end
    repeat (20) begin
      @(negedge clk);
      fd += int'(ib.field_done);
      e = 1'($urandom_range(0, 1));
      ib.rdempty_fifo = e;
      #1 chk("hold_rd", ib.rd_en_fifo, !e);
      chk("hold_req", ib.wr_req, 0);
    end
    chk("field_done_once", fd, 1);
    ib.rdempty_fifo = 1'b0;
    vs_b = 1'b1;
    k = 0;
    while (ib.wr_req !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    chk("b_resume_req", ib.wr_req, 1);
    chk("b_resume_addr", ib.wr_addr_base, 0);
    chk("b_resume_len", ib.wr_data_length, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
